// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 16;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle seen by the UART transmit arbiter.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ*8-1:0] in_req_data;
    logic [NUM_REQ-1:0]   in_req_valid;
    logic [NUM_REQ-1:0]   in_req_last;
    logic [NUM_REQ-1:0]   out_req_ready;
    logic [7:0]           out_w_data;
    logic                 out_valid;
    logic                 in_busy;
    logic [NUM_REQ-1:0]   out_grant;
    logic                 out_timeout_err;
    logic                 in_err_clear;

    // Arbiter side.
    modport master (
        input  in_req_data, in_req_valid, in_req_last, in_busy, in_err_clear,
        output out_req_ready, out_w_data, out_valid, out_grant, out_timeout_err
    );

    // Requester / transmitter side.
    modport slave (
        output in_req_data, in_req_valid, in_req_last, in_busy, in_err_clear,
        input  out_req_ready, out_w_data, out_valid, out_grant, out_timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;

    // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        req_rot = (req >> ptr) | (req << (N - 32'(ptr)));
        gnt_rot = req_rot & (~req_rot + ONE);
        gnt     = (gnt_rot << ptr) | (gnt_rot >> (N - 32'(ptr)));
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding bytes from NUM_REQ requesters
// into a single UART transmitter, with a busy-handshake watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    localparam int PW = ptr_width(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arb_state_e         state;
    arb_state_e         state_next;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      rr_ptr;
    logic [7:0]         w_data;
    logic               valid_q;
    logic               last_q;
    logic               timeout_err;
    logic [CW-1:0]      tmo_cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [7:0]         own_data;
    logic [PW-1:0]      own_idx;
    logic [PW-1:0]      ptr_after;
    logic               own_valid;
    logic               own_last;
    logic               can_issue;
    logic               xfer;
    logic               tmo_hit;
    logic               pkt_done;
    logic               grant_load;
    logic               release_grant;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req (bus.in_req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Select the owner's byte and its index from the one-hot grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        own_data = '0;
        own_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_data = own_data | bus.in_req_data[8*i +: 8];
                own_idx  = own_idx | PW'(i);
            end
        end
    end

    assign own_valid = |(bus.in_req_valid & grant);
    assign own_last  = |(bus.in_req_last & grant);
    assign can_issue = (state == ST_ISSUE) && !bus.in_busy;
    assign xfer      = can_issue && own_valid;
    assign tmo_hit   = (state == ST_WAIT_BUSY) && !bus.in_busy && (tmo_cnt == CNT_LAST);
    assign pkt_done  = tmo_hit || ((state == ST_WAIT_DONE) && !bus.in_busy);
    assign ptr_after = (own_idx == PTR_LAST) ? '0 : own_idx + PTR_ONE;

    // Next-state and grant control; a watchdog expiry is treated as done.
    always_comb begin
        state_next    = state;
        grant_load    = 1'b0;
        release_grant = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_ISSUE;
                    grant_load = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                if ((state == ST_WAIT_BUSY) && bus.in_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (pkt_done) begin
                    if (last_q) begin
                        state_next    = ST_IDLE;
                        release_grant = 1'b1;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant is held for a whole packet; the pointer advances on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else if (grant_load) begin
            grant <= pick_gnt;
        end else if (release_grant) begin
            grant  <= '0;
            rr_ptr <= ptr_after;
        end
    end

    // Capture the accepted byte and raise the one-cycle transmit request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            w_data  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= xfer;
            if (xfer) begin
                w_data <= own_data;
                last_q <= own_last;
            end
        end
    end

    // Watchdog counter: cleared on entry to WAIT_BUSY, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (xfer) begin
            tmo_cnt <= '0;
        end else if ((state == ST_WAIT_BUSY) && !bus.in_busy && (tmo_cnt != CNT_MAX)) begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end else if (bus.in_err_clear) begin
            timeout_err <= 1'b0;
        end
    end

    assign bus.out_req_ready   = can_issue ? grant : '0;
    assign bus.out_w_data      = w_data;
    assign bus.out_valid       = valid_q;
    assign bus.out_grant       = grant;
    assign bus.out_timeout_err = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus
// randomized packet traffic scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = DEF_BUSY_TIMEOUT;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   total = 0;
    int   bad   = 0;
    logic [8:0] chq [N][$];   // per-channel pending bytes {last, data}
    exp_t expq [$];           // expected transmit order
    bit   gap_en  = 1'b0;
    int   gap_pct = 0;
    bit   resp_en = 1'b0;
    bit   resp_rand = 1'b0;
    int   resp_delay = 0;
    int   resp_hold  = 3;
    int   dl = 0;
    int   hl = 0;

    // Requester driver: present queue heads, pop on handshake.
    initial begin
        bus.in_req_valid = '0;
        bus.in_req_data  = '0;
        bus.in_req_last  = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (chq[c].size() > 0 &&
                    !(gap_en && bus.out_grant[c] && ($urandom_range(0, 99) < gap_pct))) begin
                    bus.in_req_valid[c]     = 1'b1;
                    bus.in_req_data[8*c +: 8] = chq[c][0][7:0];
                    bus.in_req_last[c]      = chq[c][0][8];
                end else begin
                    bus.in_req_valid[c]     = 1'b0;
                    bus.in_req_data[8*c +: 8] = 8'($urandom_range(0, 255));
                    bus.in_req_last[c]      = 1'($urandom_range(0, 1));
                end
            end
            #1;
            for (int c = 0; c < N; c++) begin
                if (!rst && bus.in_req_valid[c] && bus.out_req_ready[c]) chq[c].delete(0);
            end
        end
    end

    // Transmitter model: after each request, stay idle dl cycles then busy hl cycles.
    initial begin
        bus.in_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (bus.out_valid === 1'b1) begin
                    if (resp_rand) begin
                        dl = int'($urandom_range(0, 4));
                        hl = int'($urandom_range(1, 4));
                    end else begin
                        dl = resp_delay;
                        hl = resp_hold;
                    end
                end
                if (dl > 0) begin
                    bus.in_busy = 1'b0;
                    dl--;
                end else if (hl > 0) begin
                    bus.in_busy = 1'b1;
                    hl--;
                end else begin
                    bus.in_busy = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every transmit request must match the next expected byte and owner.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected: got data=%h grant=%b, expected no transmit",
                             bus.out_w_data, bus.out_grant);
                end else begin
                    e = expq.pop_front();
                    if (bus.out_w_data !== e.data || bus.out_grant !== e.gnt) begin
                        bad++;
                        $display("FAIL tx_byte: got data=%h grant=%b, expected data=%h grant=%b",
                                 bus.out_w_data, bus.out_grant, e.data, e.gnt);
                    end
                end
            end
        end
    end

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push_byte(input int c, input logic [7:0] d, input logic l);
        chq[c].push_back({l, d});
    endtask

    task automatic expect_byte(input int c, input logic [7:0] d);
        exp_t e;
        e.gnt    = '0;
        e.gnt[c] = 1'b1;
        e.data   = d;
        expq.push_back(e);
    endtask

    task automatic flush_all();
        for (int c = 0; c < N; c++) chq[c].delete();
        expq.delete();
        dl = 0;
        hl = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        flush_all();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_wait_valid: no out_valid within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            done = (expq.size() == 0) && (bus.out_grant === '0) && (bus.out_valid === 1'b0);
            for (int c = 0; c < N; c++) if (chq[c].size() > 0) done = 1'b0;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, expected 0",
                     name, expq.size(), budget);
        end
    endtask

    task automatic test_reset();
        bus.in_err_clear = 1'b0;
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0; resp_hold = 2;
        rst = 1'b1;
        push_byte(1, 8'h5c, 1'b1);
        push_byte(3, 8'hc3, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (bus.out_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b, expected 0000", bus.out_grant); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, expected 0", bus.out_valid); end
        total++; if (bus.out_w_data !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h, expected 00", bus.out_w_data); end
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, expected 0", bus.out_timeout_err); end
        total++; if (bus.out_req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b, expected 0000", bus.out_req_ready); end
        rst = 1'b0;
        expect_byte(1, 8'h5c);
        expect_byte(3, 8'hc3);
        wait_drain("reset", 200);
    endtask

    task automatic test_single_packet();
        int pulses = 0;
        int wrong = 0;
        int cyc = 0;
        bit started = 1'b0;
        bit finished = 1'b0;
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0; resp_hold = 3;
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h42, 1'b1);
        expect_byte(1, 8'h41);
        expect_byte(1, 8'h42);
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) pulses++;
            if (bus.out_grant !== 4'b0000) begin
                started = 1'b1;
                if (bus.out_grant !== 4'b0010) wrong++;
            end else if (started) begin
                finished = 1'b1;
            end
        end
        total++; if (finished !== 1'b1) begin bad++; $display("FAIL single_idle: grant never cleared, expected return to idle"); end
        total++; if (pulses !== 2) begin bad++; $display("FAIL single_pulses: got %0d out_valid cycles, expected 2", pulses); end
        total++; if (wrong !== 0) begin bad++; $display("FAIL single_grant: got %0d cycles with grant other than 0010, expected 0", wrong); end
        wait_drain("single", 100);
    endtask

    task automatic test_fairness();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 1; resp_hold = 2;
        for (int k = 0; k < 3; k++) begin
            push_byte(0, 8'(8'h10 + k), 1'b1);
            push_byte(2, 8'(8'h20 + k), 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            expect_byte(0, 8'(8'h10 + k));
            expect_byte(2, 8'(8'h20 + k));
        end
        wait_drain("fairness", 400);
    endtask

    task automatic test_lock();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0; resp_hold = 2;
        push_byte(0, 8'ha0, 1'b0);
        push_byte(0, 8'ha1, 1'b0);
        push_byte(0, 8'ha2, 1'b1);
        expect_byte(0, 8'ha0);
        expect_byte(0, 8'ha1);
        expect_byte(0, 8'ha2);
        wait_valid("lock", 50);
        push_byte(3, 8'hb3, 1'b1);
        expect_byte(3, 8'hb3);
        wait_drain("lock", 200);
    endtask

    task automatic test_timeout();
        do_reset();
        resp_en = 1'b0;
        bus.in_busy = 1'b0;
        bus.in_err_clear = 1'b0;
        push_byte(1, 8'hc5, 1'b1);
        expect_byte(1, 8'hc5);
        wait_valid("timeout1", 50);
        repeat (TMO - 1) @(negedge clk);
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got err=%b one cycle before limit, expected 0", bus.out_timeout_err); end
        @(negedge clk);
        total++; if (bus.out_timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: got err=%b at limit, expected 1", bus.out_timeout_err); end
        total++; if (bus.out_grant !== 4'b0000) begin bad++; $display("FAIL timeout_release: got grant=%b, expected 0000", bus.out_grant); end
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0; resp_hold = 2;
        push_byte(2, 8'h3e, 1'b1);
        expect_byte(2, 8'h3e);
        wait_drain("timeout_continue", 100);
        total++; if (bus.out_timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got err=%b, expected 1", bus.out_timeout_err); end
        bus.in_err_clear = 1'b1;
        @(negedge clk);
        bus.in_err_clear = 1'b0;
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got err=%b, expected 0", bus.out_timeout_err); end
        // Second timeout with the clear held high throughout.
        resp_en = 1'b0;
        bus.in_busy = 1'b0;
        bus.in_err_clear = 1'b1;
        push_byte(3, 8'h7d, 1'b1);
        expect_byte(3, 8'h7d);
        wait_valid("timeout2", 50);
        repeat (TMO - 1) @(negedge clk);
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL timeout2_early: got err=%b, expected 0", bus.out_timeout_err); end
        @(negedge clk);
        total++; if (bus.out_timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set_wins: got err=%b, expected 1", bus.out_timeout_err); end
        @(negedge clk);
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL timeout2_clear: got err=%b, expected 0", bus.out_timeout_err); end
        bus.in_err_clear = 1'b0;
        wait_drain("timeout2", 100);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0; resp_hold = 4;
        push_byte(0, 8'h11, 1'b1);
        push_byte(2, 8'ha5, 1'b0);
        push_byte(2, 8'h5a, 1'b1);
        expect_byte(0, 8'h11);
        expect_byte(2, 8'ha5);
        wait_valid("midrst_a", 50);
        wait_valid("midrst_b", 50);
        @(negedge clk);
        total++; if (bus.out_grant !== 4'b0100) begin bad++; $display("FAIL midrst_owner: got grant=%b before reset, expected 0100", bus.out_grant); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.out_grant !== 4'b0000) begin bad++; $display("FAIL midrst_grant: got %b, expected 0000", bus.out_grant); end
        total++; if (bus.out_w_data !== 8'h00) begin bad++; $display("FAIL midrst_wdata: got %h, expected 00", bus.out_w_data); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid); end
        total++; if (bus.out_req_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready: got %b, expected 0000", bus.out_req_ready); end
        total++; if (bus.out_timeout_err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b, expected 0", bus.out_timeout_err); end
        flush_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_byte(2, 8'h77, 1'b1);
        push_byte(0, 8'h88, 1'b1);
        expect_byte(0, 8'h88);
        expect_byte(2, 8'h77);
        wait_drain("midrst", 200);
    endtask

    task automatic test_random();
        logic [8:0] mq [N][$];
        int ptr;
        int ch;
        int npkt;
        int len;
        logic [8:0] b;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            resp_en = 1'b1; resp_rand = 1'b1;
            gap_en = 1'b1; gap_pct = 30;
            for (int c = 0; c < N; c++) begin
                mq[c].delete();
                npkt = int'($urandom_range(0, 3));
                for (int p = 0; p < npkt; p++) begin
                    len = int'($urandom_range(1, 3));
                    for (int k = 0; k < len; k++) begin
                        b = {(k == len - 1), 8'($urandom_range(0, 255))};
                        chq[c].push_back(b);
                        mq[c].push_back(b);
                    end
                end
            end
            // Reference: whole packets in round-robin order starting at channel 0.
            ptr = 0;
            forever begin
                ch = -1;
                for (int k = 0; k < N; k++) begin
                    if (ch < 0 && mq[(ptr + k) % N].size() > 0) ch = (ptr + k) % N;
                end
                if (ch < 0) break;
                do begin
                    b = mq[ch].pop_front();
                    expect_byte(ch, b[7:0]);
                end while (b[8] == 1'b0);
                ptr = (ch + 1) % N;
            end
            wait_drain("random", 3000);
            gap_en = 1'b0;
        end
    endtask

    initial begin
        bus.in_err_clear = 1'b0;
        rst = 1'b1;
        test_reset();
        test_single_packet();
        test_fairness();
        test_lock();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requester channels (2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for in_busy to rise after an issue.
REQ-003 The block SHALL have port clk  input  1  the single system clock.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_req_data  input  NUM_REQ*8  data bytes; channel i occupies bits [8i+7:8i].
REQ-006 The block SHALL have port in_req_valid  input  NUM_REQ  per-channel byte valid.
REQ-007 The block SHALL have port in_req_last  input  NUM_REQ  per-channel last-byte-of-packet flag.
REQ-008 The block SHALL have port out_req_ready  output  NUM_REQ  per-channel byte accept.
REQ-009 The block SHALL have port out_w_data  output  8  byte to the UART transmitter.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle transmit request.
REQ-011 The block SHALL have port in_busy  input  1  transmitter busy.
REQ-012 The block SHALL have port out_grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
REQ-013 The block SHALL have port out_timeout_err  output  1  sticky timeout flag.
REQ-014 The block SHALL have port in_err_clear  input  1  clears out_timeout_err.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE, when any in_req_valid is high, the block SHALL register a one-hot grant to the first valid channel at or after rr_ptr (cyclic order) and enter ISSUE on the next cycle.
REQ-017 out_req_ready[i] SHALL be combinational: high only in ISSUE, with out_grant[i]=1 and in_busy=0.
REQ-018 A transfer SHALL occur at a clock edge where in_req_valid[i] and out_req_ready[i] are both high; the block SHALL capture the data and the last flag.
REQ-019 The cycle after a transfer, out_valid SHALL be 1 for exactly one cycle with out_w_data equal to the captured byte, and the state SHALL become WAIT_BUSY.
REQ-020 out_w_data SHALL hold its value until the next transfer.
REQ-021 In WAIT_BUSY, in_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-022 In WAIT_BUSY, if in_busy stays low for BUSY_TIMEOUT cycles, the block SHALL set out_timeout_err and proceed as if done.
REQ-023 In WAIT_DONE, in_busy=0 SHALL move to IDLE if the captured last was 1, otherwise to ISSUE.
REQ-024 On the return to IDLE the grant SHALL clear, and rr_ptr SHALL become (granted index + 1) mod NUM_REQ.
REQ-025 The grant SHALL never change mid-packet; if the owner drops valid in ISSUE, the block SHALL wait there indefinitely.
REQ-026 Other channels' valids SHALL be ignored while a grant is held.
REQ-027 If timeout set and in_err_clear occur in the same cycle, set SHALL win.
REQ-028 The timeout counter SHALL be sized $clog2(BUSY_TIMEOUT+1), SHALL reset on entry to WAIT_BUSY, and SHALL saturate.

Reset
REQ-029 rst SHALL asynchronously force IDLE, rr_ptr=0, and out_grant, out_valid, out_w_data, out_timeout_err and the counter to 0, including mid-packet.
REQ-030 out_req_ready SHALL be 0 while rst is high.
REQ-031 After rst releases, the first arbitration SHALL start from channel 0.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick (request vector, pointer -> one-hot grant, any).
REQ-034 All other logic SHALL be in uart_tx_arbiter.

Verification
REQ-035 Single packet: ch1 sends 0x41, 0x42 (last) with in_busy high for 3 cycles after each out_valid -> two out_valid pulses carrying 0x41 then 0x42, grant=0010 throughout, then idle.
REQ-036 Fairness: ch0 and ch2 request continuously with 1-byte packets -> grants alternate 0001, 0100, 0001, ...
REQ-037 Lock: ch0 sends a 3-byte packet while ch3 raises valid after byte 1 -> ch3 is granted only after ch0's last byte completes.
REQ-038 Timeout: in_busy held 0 after an issue -> out_timeout_err=1 after 16 cycles, FSM continues; in_err_clear clears the flag.
REQ-039 Reset mid-packet: rst asserted in WAIT_DONE -> all outputs 0 immediately; after release, ch0 wins over ch2 when both are requesting.
